// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game sequencing logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam logic [1:0] LEVEL_MAX   = 2'd3;
  localparam logic       SERVE_RIGHT = 1'b1;
  localparam logic       SERVE_LEFT  = 1'b0;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter. It steps once per enabled frame and flags when it reaches zero.
module frame_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over the decrement, and the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst)                   count <= '0;
    else if (load)             count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencer: serve countdown, rally speed escalation, scoring and match end.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int LEVEL_FRAMES = 600,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               finish_frame,
  input  logic               p1_win,
  input  logic               p2_win,
  output logic               origin,
  output logic               serve,
  output logic [1:0]         level_state,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > LEVEL_FRAMES) ? SERVE_FRAMES : LEVEL_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   LEVEL_LOAD = CNT_W'(LEVEL_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  game_state_t        state, state_n;
  logic [SCORE_W-1:0] score1_n, score2_n, score1_inc, score2_inc;
  logic [1:0]         level_n;
  logic               serve_n, winner_n;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;

  assign score1_inc = score1 + 1'b1;
  assign score2_inc = score2 + 1'b1;

  frame_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State and game registers; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      score1      <= '0;
      score2      <= '0;
      level_state <= 2'd0;
      serve       <= SERVE_RIGHT;
      winner      <= 1'b0;
    end else begin
      state       <= state_n;
      score1      <= score1_n;
      score2      <= score2_n;
      level_state <= level_n;
      serve       <= serve_n;
      winner      <= winner_n;
    end
  end

  // Next-state and next-register decode; a point in PLAY overrides any level step.
  always_comb begin
    state_n  = state;
    score1_n = score1;
    score2_n = score2;
    level_n  = level_state;
    serve_n  = serve;
    winner_n = winner;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SERVE;
          tmr_load = 1'b1;
          tmr_val  = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (finish_frame) begin
          if (tmr_zero) begin
            state_n  = PLAY;
            level_n  = 2'd0;
            tmr_load = 1'b1;
            tmr_val  = LEVEL_LOAD;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      PLAY: begin
        if (p1_win || p2_win) begin
          level_n  = 2'd0;
          tmr_load = 1'b1;
          tmr_val  = SERVE_LOAD;
          state_n  = SERVE;
          if (p1_win) begin
            score1_n = score1_inc;
            serve_n  = SERVE_RIGHT;
            if (score1_inc == WIN_S) begin
              state_n  = GAME_OVER;
              winner_n = 1'b0;
            end
          end else begin
            score2_n = score2_inc;
            serve_n  = SERVE_LEFT;
            if (score2_inc == WIN_S) begin
              state_n  = GAME_OVER;
              winner_n = 1'b1;
            end
          end
        end else if (finish_frame) begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = LEVEL_LOAD;
            level_n  = (level_state == LEVEL_MAX) ? LEVEL_MAX : level_state + 2'd1;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_n  = SERVE;
          score1_n = '0;
          score2_n = '0;
          serve_n  = SERVE_RIGHT;
          tmr_load = 1'b1;
          tmr_val  = SERVE_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign origin    = (state != PLAY);
  assign game_over = (state == GAME_OVER);

endmodule
